// File: rtl/lmsm_pkg.sv
// Shared state encoding and transfer-direction constants for the LM/SM sequencer.
// Imported by the sequencer top; carries no logic of its own.
package lmsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_LM = 1'b0;
  localparam logic MODE_SM = 1'b1;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational, zero latency.
// valid is low and idx is 0 when no bit is set.
module prio_enc #(
  parameter int NREG = 8,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic [NREG-1:0] mask,
  output logic [RAW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) idx = RAW'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask lowest-first, one memory request per set bit.
// Two cycles per register plus one DONE cycle; MEM holds its request until mem_ack, with no timeout.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int STEP = 1,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [NREG-1:0] mask,
  input  logic [AW-1:0]   base,
  output logic            busy,
  output logic            done,
  output logic [RAW:0]    count,
  output logic [AW-1:0]   end_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic [RAW-1:0]  rf_raddr,
  input  logic [DW-1:0]   rf_rdata,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [DW-1:0]   rf_wdata
);

  state_t          state_q, state_d;
  logic            mode_q;
  logic [NREG-1:0] mask_q;
  logic [AW-1:0]   addr_q;
  logic [RAW:0]    count_q;
  logic [RAW-1:0]  idx_q;
  logic [RAW-1:0]  pe_idx;
  logic            pe_valid;
  logic [NREG-1:0] mask_clr;

  prio_enc #(.NREG(NREG), .RAW(RAW)) u_prio_enc (
    .mask  (mask_q),
    .idx   (pe_idx),
    .valid (pe_valid)
  );

  assign mask_clr = mask_q & ~(NREG'(1) << idx_q);

  assign mem_addr = addr_q;
  assign rf_raddr = idx_q;
  assign rf_waddr = idx_q;
  assign rf_wdata = mem_rdata;
  assign end_addr = addr_q;
  assign count    = count_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (mask == '0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        busy    = 1'b1;
        state_d = pe_valid ? ST_MEM : ST_DONE;
      end
      ST_MEM: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = mode_q;
        mem_wdata = rf_rdata;
        if (mem_ack) begin
          rf_we   = (mode_q == MODE_LM);
          state_d = (mask_clr == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset clears the mask so an interrupted transfer leaves nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LM;
      mask_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            mask_q  <= mask;
            addr_q  <= base;
            count_q <= '0;
          end
        end
        ST_SCAN: idx_q <= pe_idx;
        ST_MEM: begin
          if (mem_ack) begin
            mask_q  <= mask_clr;
            addr_q  <= addr_q + AW'(STEP);
            count_q <= count_q + (RAW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 Parameter NREG, default 8: number of architectural registers covered by the mask.
REQ-002 Parameter DW, default 16: register and memory data width.
REQ-003 Parameter AW, default 16: memory address width.
REQ-004 Parameter STEP, default 1: address increment per transferred register.
REQ-005 Derived RAW = clog2(NREG): register index width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  request a block transfer; sampled only in IDLE.
REQ-009 mode  in  1  0 = load-multiple (LM), 1 = store-multiple (SM); latched on start.
REQ-010 mask  in  NREG  register-select bitmask; latched on start.
REQ-011 base  in  AW  first memory address; latched on start.
REQ-012 busy  out  1  high in SCAN and MEM.
REQ-013 done  out  1  one-cycle pulse in DONE.
REQ-014 count  out  RAW+1  number of registers transferred so far in the current operation.
REQ-015 end_addr  out  AW  address following the last transfer; valid from DONE until next start.
REQ-016 mem_req / mem_we  out  1 / 1  memory request and write qualifier.
REQ-017 mem_addr / mem_wdata  out  AW / DW  request address and store data.
REQ-018 mem_ack / mem_rdata  in  1 / DW  request completion and load data.
REQ-019 rf_raddr / rf_rdata  out RAW / in DW  register-file read port (combinational read).
REQ-020 rf_we / rf_waddr / rf_wdata  out  1 / RAW / DW  register-file write port.

Function
REQ-021 States SHALL be IDLE, SCAN, MEM and DONE.
REQ-022 In IDLE with start=1, the block SHALL latch mode, mask and base into mode_q, mask_q and addr_q, and clear count.
REQ-023 From IDLE with start=1, the next state SHALL be DONE if mask=0 and SCAN otherwise.
REQ-024 In SCAN, the block SHALL select idx = the lowest set bit of mask_q and move to MEM in one cycle.
REQ-025 In MEM, mem_req SHALL be 1, mem_we SHALL equal mode_q, mem_addr SHALL equal addr_q, rf_raddr SHALL equal idx, and mem_wdata SHALL equal rf_rdata.
REQ-026 MEM SHALL hold every request output stable until mem_ack=1, with no timeout.
REQ-027 On mem_ack in MEM with mode_q=0, rf_we SHALL pulse in that cycle with rf_waddr=idx and rf_wdata=mem_rdata.
REQ-028 On mem_ack in MEM, the block SHALL clear mask_q[idx], add STEP to addr_q modulo 2^AW, and increment count.
REQ-029 After mem_ack in MEM, the next state SHALL be DONE if the updated mask_q is 0 and SCAN otherwise.
REQ-030 DONE SHALL assert done for exactly one cycle, present end_addr=addr_q, and return to IDLE.
REQ-031 With k set bits and mem_ack returned in the first MEM cycle, done SHALL assert 2k+1 cycles after the start edge.
REQ-032 start outside IDLE SHALL be ignored, and mem_ack outside MEM SHALL be ignored.
REQ-033 rf_we SHALL never assert when mode_q=1, and mem_req SHALL never assert outside MEM.
REQ-034 Registers SHALL be transferred in ascending index order, with addresses ascending by STEP.

Reset
REQ-035 On rst_n=0, the block SHALL asynchronously enter IDLE.
REQ-036 During reset, mask_q, addr_q, count and end_addr SHALL be 0.
REQ-037 During reset, busy, done, mem_req, mem_we and rf_we SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abandon the transfer with no further rf_we or mem_req, and remaining mask bits SHALL be discarded.

Structure
REQ-039 State encoding and the LM/SM mode constants SHALL live in shared package lmsm_pkg.
REQ-040 Lowest-set-bit selection SHALL be sub-module prio_enc, parametrised by NREG, with outputs idx and valid.

Verification
REQ-041 LM with mask=8'b1010_0001, base=0x0040 and immediate ack -> rf writes to R0, R5, R7 from 0x40, 0x41, 0x42; done at cycle 7; count=3; end_addr=0x43.
REQ-042 SM with mask=8'hFF, base=0x1000 and ack delayed 3 cycles per request -> 8 writes to 0x1000..0x1007 with mem_wdata=R0..R7; request outputs stable across waits; no rf_we.
REQ-043 mask=0 with start -> done one cycle after the start edge; no mem_req; count=0; end_addr=base.
REQ-044 base=0xFFFE with mask=8'b0000_0111 -> addresses 0xFFFE, 0xFFFF, 0x0000; end_addr=0x0001.
REQ-045 start pulsed while busy, and stray mem_ack in SCAN -> both ignored; transfer sequence unchanged.
REQ-046 rst_n low during the second MEM of a 4-register LM -> immediate IDLE, all outputs 0, no further rf_we; a new start then runs normally.
